// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port framebuffer RAM between VGA scan-out
// prefetch (raster-order reads into a small FIFO) and a draw-engine write port.
// Reads are decided in cycle t, presented on o_mem_* in t+1, and their data is
// pushed into the FIFO at the end of t+2.
module vga_fb_arbiter #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 8,
  parameter int H_ACTIVE   = 1024,
  parameter int V_ACTIVE   = 768,
  parameter int FIFO_DEPTH = 32,
  parameter int LOW_WM     = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_pix_stb,
  input  logic              i_frame_start,
  input  logic              i_pix_req,
  output logic [DATA_W-1:0] o_pix_data,
  input  logic              i_wr_valid,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ready,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_underflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = ADDR_W + 1;

  localparam logic [CNT_W-1:0] TOTAL    = CNT_W'(H_ACTIVE * V_ACTIVE);
  localparam logic [CNT_W-1:0] LAST     = TOTAL - CNT_W'(1);
  localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] LOW_L    = LVL_W'(LOW_WM);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]        state;
  logic [1:0]        next_state;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [LVL_W-1:0]  count;
  logic              fly_a;
  logic              fly_b;
  logic [CNT_W-1:0]  fetch_addr;

  logic [LVL_W-1:0]  level;
  logic              fifo_empty;
  logic              have_addr;
  logic              wr_go;
  logic              rd_go;
  logic              pop_req;
  logic              pop_go;
  logic              push_go;
  logic              last_issue;

  // fly_a: read on o_mem_* now; fly_b: its data is on i_mem_rdata now
  assign level      = count + LVL_W'(fly_a) + LVL_W'(fly_b);
  assign fifo_empty = (count == '0);
  assign have_addr  = (fetch_addr < TOTAL);
  assign o_pix_data = fifo_empty ? '0 : fifo_mem[rd_ptr];

  // Writer grant depends only on state and level, never on i_wr_valid
  always_comb begin
    o_wr_ready = 1'b0;
    case (state)
      ST_IDLE: o_wr_ready = 1'b1;
      ST_FILL: o_wr_ready = 1'b0;
      ST_RUN:  o_wr_ready = (level >= LOW_L);
      ST_DONE: o_wr_ready = 1'b1;
      default: o_wr_ready = 1'b0;
    endcase
  end

  // Per-cycle RAM arbitration: urgent reads beat writes, spare cycles top up the FIFO
  always_comb begin
    wr_go      = i_wr_valid & o_wr_ready;
    rd_go      = ~i_frame_start & ~wr_go & have_addr &
                 ((state == ST_FILL) | (state == ST_RUN)) & (level < DEPTH_L);
    pop_req    = i_pix_stb & i_pix_req & ~i_frame_start;
    pop_go     = pop_req & ~fifo_empty;
    push_go    = fly_b & ~i_frame_start;
    last_issue = rd_go & (fetch_addr == LAST);
  end

  // Next-state selection; a frame start always restarts the fill
  always_comb begin
    next_state = state;
    if (i_frame_start) begin
      next_state = ST_FILL;
    end else begin
      case (state)
        ST_FILL: begin
          if (last_issue)          next_state = ST_DONE;
          else if (level == DEPTH_L) next_state = ST_RUN;
        end
        ST_RUN: begin
          if (last_issue) next_state = ST_DONE;
        end
        default: next_state = state;
      endcase
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge i_clk) begin
    if (push_go) fifo_mem[wr_ptr] <= i_mem_rdata;
  end

  // Control state, FIFO pointers, fetch address and registered RAM interface
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      fly_a       <= 1'b0;
      fly_b       <= 1'b0;
      fetch_addr  <= '0;
      o_mem_en    <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_underflow <= 1'b0;
    end else begin
      state       <= next_state;
      o_mem_en    <= rd_go | wr_go;
      o_mem_we    <= wr_go;
      o_mem_addr  <= wr_go ? i_wr_addr : (rd_go ? fetch_addr[ADDR_W-1:0] : '0);
      o_mem_wdata <= wr_go ? i_wr_data : '0;
      fly_a       <= rd_go;
      fly_b       <= fly_a & ~i_frame_start;
      if (pop_req && fifo_empty) o_underflow <= 1'b1;
      if (i_frame_start) begin
        fetch_addr <= '0;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        count      <= '0;
      end else begin
        if (rd_go)   fetch_addr <= fetch_addr + CNT_W'(1);
        if (push_go) wr_ptr     <= wr_ptr + PTR_W'(1);
        if (pop_go)  rd_ptr     <= rd_ptr + PTR_W'(1);
        count <= count + LVL_W'(push_go) - LVL_W'(pop_go);
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed scenarios followed by a randomized run, every
// cycle compared against a queue-based reference model of the arbiter.
module tb_vga_fb_arbiter;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int LOW    = 2;
  localparam int TOTAL  = 16;

  logic              i_clk;
  logic              i_rst;
  logic              i_pix_stb;
  logic              i_frame_start;
  logic              i_pix_req;
  logic [DATA_W-1:0] o_pix_data;
  logic              i_wr_valid;
  logic [ADDR_W-1:0] i_wr_addr;
  logic [DATA_W-1:0] i_wr_data;
  logic              o_wr_ready;
  logic              o_mem_en;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata;
  logic              o_underflow;

  int checks;
  int failures;

  // Reference model: FIFO contents, data of the two in-flight reads (-1 = none)
  string             m_state;
  int                m_fifo[$];
  int                m_ret1;
  int                m_ret2;
  int                m_fetch;
  bit                m_uf;
  bit                exp_en;
  bit                exp_we;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_wdata;

  vga_fb_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .H_ACTIVE(8), .V_ACTIVE(2),
    .FIFO_DEPTH(DEPTH), .LOW_WM(LOW)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_pix_stb(i_pix_stb),
    .i_frame_start(i_frame_start), .i_pix_req(i_pix_req),
    .o_pix_data(o_pix_data), .i_wr_valid(i_wr_valid), .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data), .o_wr_ready(o_wr_ready), .o_mem_en(o_mem_en),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata), .o_underflow(o_underflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Framebuffer RAM holds mem[a] = a+1; read data appears one cycle after issue
  always @(posedge i_clk) begin
    if (o_mem_en === 1'b1 && o_mem_we === 1'b0)
      i_mem_rdata <= DATA_W'(o_mem_addr + 20'd1);
    else
      i_mem_rdata <= 8'hEE;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    m_state = "IDLE";
    m_fifo.delete();
    m_ret1 = -1;
    m_ret2 = -1;
    m_fetch = 0;
    m_uf = 1'b0;
    exp_en = 1'b0;
    exp_we = 1'b0;
    exp_addr = '0;
    exp_wdata = '0;
  endtask

  // One clock cycle: drive inputs, check combinational outputs, advance model, check registers
  task automatic applyStimulus(input bit rst, input bit fs, input bit stb,
                               input bit req, input bit wv,
                               input logic [ADDR_W-1:0] wa,
                               input logic [DATA_W-1:0] wd);
    int level;
    bit ready;
    bit wr;
    bit rd;
    @(negedge i_clk);
    i_rst = rst;
    i_frame_start = fs;
    i_pix_stb = stb;
    i_pix_req = req;
    i_wr_valid = wv;
    i_wr_addr = wa;
    i_wr_data = wd;
    #1;
    level = m_fifo.size() + ((m_ret1 >= 0) ? 1 : 0) + ((m_ret2 >= 0) ? 1 : 0);
    ready = (m_state == "IDLE") || (m_state == "DONE") ||
            ((m_state == "RUN") && (level >= LOW));
    checkOutput("wr_ready", o_wr_ready, ready);
    checkOutput("pix_data", o_pix_data, (m_fifo.size() > 0) ? m_fifo[0] : 0);
    if (rst) begin
      modelReset();
    end else begin
      wr = wv && ready;
      rd = !fs && !wr && (m_fetch < TOTAL) &&
           ((m_state == "FILL") || (m_state == "RUN")) && (level < DEPTH);
      exp_en = rd || wr;
      exp_we = wr;
      exp_addr = wr ? wa : (rd ? ADDR_W'(m_fetch) : '0);
      exp_wdata = wr ? wd : '0;
      if (fs) begin
        m_fifo.delete();
        m_ret1 = -1;
        m_ret2 = -1;
        m_fetch = 0;
        m_state = "FILL";
      end else begin
        if (stb && req) begin
          if (m_fifo.size() == 0) m_uf = 1'b1;
          else void'(m_fifo.pop_front());
        end
        if (m_ret2 >= 0) m_fifo.push_back(m_ret2);
        m_ret2 = m_ret1;
        m_ret1 = rd ? m_fetch + 1 : -1;
        if (rd && m_fetch == TOTAL - 1) m_state = "DONE";
        else if (m_state == "FILL" && level == DEPTH) m_state = "RUN";
        if (rd) m_fetch++;
      end
    end
    @(posedge i_clk);
    #1;
    checkOutput("mem_en", o_mem_en, exp_en);
    checkOutput("mem_we", o_mem_we, exp_we);
    checkOutput("mem_addr", o_mem_addr, exp_addr);
    checkOutput("mem_wdata", o_mem_wdata, exp_wdata);
    checkOutput("underflow", o_underflow, m_uf);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, '0, '0);
  endtask

  initial begin
    int n;
    checks = 0;
    failures = 0;
    i_rst = 1'b1;
    i_frame_start = 1'b0;
    i_pix_stb = 1'b0;
    i_pix_req = 1'b0;
    i_wr_valid = 1'b0;
    i_wr_addr = '0;
    i_wr_data = '0;
    repeat (2) @(posedge i_clk);
    #1;
    modelReset();
    checkOutput("rst_mem_en", o_mem_en, 0);
    checkOutput("rst_pix", o_pix_data, 0);
    checkOutput("rst_uf", o_underflow, 0);
    checkOutput("rst_ready_idle", o_wr_ready, 1);

    // Pop before any frame: underflow sets and survives a frame start
    applyStimulus(0, 0, 0, 0, 0, '0, '0);
    applyStimulus(0, 0, 1, 1, 0, '0, '0);
    checkOutput("t5_pix", o_pix_data, 0);
    checkOutput("t5_uf", o_underflow, 1);
    applyStimulus(0, 1, 0, 0, 0, '0, '0);
    idleCycles(2);
    checkOutput("t5_uf_kept", o_underflow, 1);
    applyStimulus(1, 0, 0, 0, 0, '0, '0);
    checkOutput("t5_uf_cleared", o_underflow, 0);

    // Frame start fills the FIFO with addresses 0..3 back to back
    applyStimulus(0, 1, 0, 0, 0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, '0, '0);
      checkOutput("t1_rd_en", o_mem_en, 1);
      checkOutput("t1_rd_addr", o_mem_addr, i);
    end
    idleCycles(3);
    for (int k = 1; k <= 4; k++) begin
      checkOutput("t1_pop_pix", o_pix_data, k);
      applyStimulus(0, 0, 1, 1, 0, '0, '0);
    end

    // Writer held valid while pixels are popped every fourth cycle
    n = 5;
    for (int c = 0; c < 300 && n <= 16; c++) begin
      if (c % 4 == 3) begin
        checkOutput("t2_pop_pix", o_pix_data, n);
        applyStimulus(0, 0, 1, 1, 1, ADDR_W'($urandom_range(1000, 32)), DATA_W'($urandom));
        n++;
      end else begin
        applyStimulus(0, 0, 0, 0, 1, ADDR_W'($urandom_range(1000, 32)), DATA_W'($urandom));
      end
    end
    checkOutput("t2_all_popped", n, 17);
    checkOutput("t2_uf", o_underflow, 0);

    // Whole frame fetched: no more reads, writes granted
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, '0, '0);
      checkOutput("t3_no_read", o_mem_en, 0);
    end
    checkOutput("t3_ready", o_wr_ready, 1);
    applyStimulus(0, 0, 0, 0, 1, 20'd5, 8'hAA);
    checkOutput("t3_we", o_mem_we, 1);
    checkOutput("t3_addr", o_mem_addr, 5);
    checkOutput("t3_wdata", o_mem_wdata, 8'hAA);

    // Frame restart while a read is in flight and the FIFO holds data
    applyStimulus(0, 1, 0, 0, 0, '0, '0);
    idleCycles(6);
    applyStimulus(0, 0, 1, 1, 0, '0, '0);
    applyStimulus(0, 0, 0, 0, 0, '0, '0);
    checkOutput("t4_read_issued", o_mem_en, 1);
    applyStimulus(0, 1, 0, 0, 0, '0, '0);
    checkOutput("t4_flushed_pix", o_pix_data, 0);
    applyStimulus(0, 0, 0, 0, 0, '0, '0);
    checkOutput("t4_restart_addr", o_mem_addr, 0);
    checkOutput("t4_restart_en", o_mem_en, 1);
    idleCycles(4);
    checkOutput("t4_first_pix", o_pix_data, 1);

    // Reset during RUN in the same cycle a write is accepted
    applyStimulus(0, 1, 0, 0, 0, '0, '0);
    idleCycles(6);
    checkOutput("t6_ready_before", o_wr_ready, 1);
    applyStimulus(1, 0, 0, 0, 1, 20'd7, 8'h55);
    checkOutput("t6_mem_en", o_mem_en, 0);
    checkOutput("t6_mem_we", o_mem_we, 0);
    checkOutput("t6_mem_addr", o_mem_addr, 0);
    checkOutput("t6_mem_wdata", o_mem_wdata, 0);
    checkOutput("t6_pix", o_pix_data, 0);
    checkOutput("t6_uf", o_underflow, 0);

    // Randomized traffic against the reference model
    for (int c = 0; c < 1500; c++) begin
      applyStimulus(($urandom_range(299, 0) == 0),
                    ($urandom_range(59, 0) == 0),
                    ($urandom_range(2, 0) == 0),
                    ($urandom_range(3, 0) != 0),
                    ($urandom_range(1, 0) == 0),
                    ADDR_W'($urandom),
                    DATA_W'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
